gcd_lcm_arbiter: RTL and testbench
==================================

Name: gcd_lcm_arbiter

Overview:
- Shares one GCD/LCM iterative compute unit (controller plus datapath) between NREQ requesters.
- Grants requests in round-robin order and presents the latched operands and op to the unit.
- Holds the unit's start high until it reports done, then returns the result to the granted requester.
- Adds zero-operand rejection and a timeout watchdog so a stuck unit can never hang the bus.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 8, operand/result width.
- TIMEOUT, 1023, max cycles in RUN before abort (>=2).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester request level; held until own rsp_valid.
- req_op  in  NREQ  per-requester op: 0 = GCD, 1 = LCM.
- req_x  in  NREQ*W  packed x operands; requester i at [i*W +: W].
- req_y  in  NREQ*W  packed y operands; same packing as req_x.
- rsp_valid  out  NREQ  one-cycle one-hot response strobe.
- rsp_result  out  W  result, valid with rsp_valid.
- rsp_err  out  1  1 = zero operand or timeout, valid with rsp_valid.
- u_start  out  1  start level to the unit.
- u_op  out  1  op to the unit.
- u_x  out  W  x operand to the unit.
- u_y  out  W  y operand to the unit.
- u_clr  out  1  one-cycle synchronous clear pulse to the unit (returns it to its idle state).
- u_done  in  1  unit done, combinational, one cycle.
- u_result  in  W  unit result, valid when u_done=1.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async):
  - state=IDLE; last_grant=NREQ-1 (requester 0 has first priority).
  - All outputs 0; latched op/x/y/id 0; timeout counter 0.
- States: IDLE, RUN, ABORT, RESP.
- IDLE:
  - If any req bit is set, grant the first requester at or after last_grant+1 (mod NREQ).
  - Latch id, op, x, y from the granted requester.
  - If latched x==0 or y==0: go to RESP with err=1, result=0; u_start is never asserted.
  - Otherwise go to RUN with the counter cleared.
- RUN:
  - u_start=1; u_op/u_x/u_y driven from the latched values, stable for the entire RUN.
  - Counter increments each cycle.
  - If u_done=1: capture u_result, err=0, go to RESP.
  - Else if counter==TIMEOUT-1: go to ABORT.
  - u_done and the timeout condition in the same cycle: done wins.
- ABORT:
  - u_start=0, u_clr=1 for exactly one cycle.
  - Then go to RESP with err=1, result=0.
- RESP:
  - u_start=0.
  - rsp_valid[id]=1 for exactly one cycle, with rsp_result and rsp_err registered and driven.
  - last_grant=id; next state IDLE.
  - rsp_result and rsp_err return to 0 outside RESP.
- Latency:
  - Request seen in IDLE at cycle k; u_start is first high at k+1.
  - rsp_valid is high the cycle after u_done.
  - Minimum round trip for a zero operand: rsp_valid at k+1.
- Operands:
  - The unit only ever sees latched copies.
  - Requester changes to x/y/op after the grant are ignored until the next grant.
- Withdrawal: if req drops while granted, the operation still completes and the rsp_valid pulse is still issued (the requester discards it).
- Back-to-back: after RESP, IDLE arbitrates the same cycle it is entered; there is one idle cycle minimum between operations.
- Fairness: a requester that holds req is granted within NREQ operations.
- Reset mid-operation: immediate return to reset values; no response is issued and u_clr is not pulsed (the unit shares the reset).
- The unit is never started while u_clr=1 or in RESP.

Test Plan:
- Req0 GCD x=48 y=18 with the real unit → u_start high from k+1 until done; rsp_valid=4'b0001, rsp_result=6, rsp_err=0.
- Req1 LCM x=4 y=6 → rsp_valid=4'b0010, rsp_result=12, rsp_err=0; u_op=1 throughout RUN.
- req=4'b1111 held after reset → responses in order 0,1,2,3,0; after a grant to 2 with req=4'b0101, the next grant is 0.
- Req3 x=0 y=9 → rsp_valid=4'b1000 at k+1, rsp_err=1, rsp_result=0; u_start never asserted.
- Stub unit never asserts done, TIMEOUT=16 → u_start high 16 cycles, u_clr pulse of one cycle, then rsp_err=1; the next request is serviced normally.
- Assert reset mid-RUN → all outputs 0 asynchronously, no rsp_valid; after release, requester 0 is granted first.
- u_done asserted on the timeout cycle → normal response with err=0 and no u_clr pulse.

Source files
------------

// File: rtl/gcd_lcm_arbiter.sv
// -----------------------------------------------------------------------------
// gcd_lcm_arbiter
//
// Shares one iterative GCD/LCM compute unit between NREQ requesters.
// Requests are granted round-robin. The granted requester's op and operands
// are latched and presented to the unit, whose start level is held until it
// reports done. The result then goes back to the granted requester as a
// one-cycle strobe. Zero operands are rejected without starting the unit, and
// a watchdog aborts a unit that never finishes, so the bus can never hang.
//
// Parameters
//   NREQ     number of requesters (2..8)
//   W        operand / result width
//   TIMEOUT  maximum cycles spent in RUN before the operation is aborted (>=2)
//
// Ports
//   clk         clock, rising edge
//   reset       asynchronous, active-high reset
//   req         per-requester request level, held until own rsp_valid
//   req_op      per-requester op: 0 = GCD, 1 = LCM
//   req_x       packed x operands, requester i at [i*W +: W]
//   req_y       packed y operands, same packing as req_x
//   rsp_valid   one-cycle one-hot response strobe
//   rsp_result  result, valid with rsp_valid (0 otherwise)
//   rsp_err     1 = zero operand or timeout, valid with rsp_valid (0 otherwise)
//   u_start     start level to the unit (high for the whole of RUN)
//   u_op        op to the unit (latched copy)
//   u_x         x operand to the unit (latched copy)
//   u_y         y operand to the unit (latched copy)
//   u_clr       one-cycle synchronous clear pulse to the unit
//   u_done      unit done, combinational, one cycle
//   u_result    unit result, valid when u_done = 1
//   busy        high in any state other than IDLE
// -----------------------------------------------------------------------------
module gcd_lcm_arbiter #(
    parameter int NREQ    = 4,
    parameter int W       = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   req_op,
    input  logic [NREQ*W-1:0] req_x,
    input  logic [NREQ*W-1:0] req_y,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [W-1:0]      rsp_result,
    output logic              rsp_err,
    output logic              u_start,
    output logic              u_op,
    output logic [W-1:0]      u_x,
    output logic [W-1:0]      u_y,
    output logic              u_clr,
    input  logic              u_done,
    input  logic [W-1:0]      u_result,
    output logic              busy
);

    localparam int IDW = $clog2(NREQ);
    // The counter only has to reach TIMEOUT-1 before RUN is left.
    localparam int CW  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [IDW-1:0] LAST_RST = IDW'(NREQ - 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        ABORT = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [IDW-1:0]  last_q;
    logic [IDW-1:0]  id_q;
    logic            op_q;
    logic [W-1:0]    x_q;
    logic [W-1:0]    y_q;
    logic [W-1:0]    res_q;
    logic            err_q;
    logic [CW-1:0]   cnt_q;

    logic [IDW-1:0]  gnt_id;
    logic            gnt_op;
    logic [W-1:0]    gnt_x;
    logic [W-1:0]    gnt_y;
    logic            gnt_zero;
    logic            any_req;

    // Round-robin pick: the requester closest after 'last' (wrapping) wins.
    // Distance is measured with constant loop indices so no run-time index
    // into the request vector is needed.
    function automatic logic [IDW-1:0] rr_pick(input logic [IDW-1:0] last,
                                               input logic [NREQ-1:0] r);
        logic [IDW-1:0] pick;
        int             best_d;
        int             d;
        pick   = '0;
        best_d = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            d = (i + NREQ - int'(last) - 1) % NREQ;
            if (r[i] && (d < best_d)) begin
                best_d = d;
                pick   = IDW'(i);
            end
        end
        return pick;
    endfunction

    assign any_req = |req;
    assign gnt_id  = rr_pick(last_q, req);

    // Mux the granted requester's op and operands.
    always_comb begin
        gnt_op = 1'b0;
        gnt_x  = '0;
        gnt_y  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_id == IDW'(i)) begin
                gnt_op = req_op[i];
                gnt_x  = req_x[i*W +: W];
                gnt_y  = req_y[i*W +: W];
            end
        end
    end

    assign gnt_zero = (gnt_x == '0) || (gnt_y == '0);

    // Next-state logic. In RUN, u_done is checked before the watchdog so a
    // unit that finishes on the last allowed cycle still delivers its result.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = gnt_zero ? RESP : RUN;
                end
            end
            RUN: begin
                if (u_done) begin
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ABORT;
                end
            end
            ABORT:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, latched request and response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= LAST_RST;
            id_q    <= '0;
            op_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        id_q  <= gnt_id;
                        op_q  <= gnt_op;
                        x_q   <= gnt_x;
                        y_q   <= gnt_y;
                        cnt_q <= '0;
                        res_q <= '0;
                        // A zero operand goes straight to RESP as an error.
                        err_q <= gnt_zero;
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (u_done) begin
                        res_q <= u_result;
                        err_q <= 1'b0;
                    end
                end
                ABORT: begin
                    res_q <= '0;
                    err_q <= 1'b1;
                end
                RESP: begin
                    last_q <= id_q;
                end
                default: ;
            endcase
        end
    end

    // Unit interface: the unit only ever sees the latched copies, so
    // requester-side changes after the grant have no effect.
    assign u_start = (state_q == RUN);
    assign u_clr   = (state_q == ABORT);
    assign u_op    = op_q;
    assign u_x     = x_q;
    assign u_y     = y_q;
    assign busy    = (state_q != IDLE);

    // Response strobe to the granted requester; result/err are forced to 0
    // outside RESP.
    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            rsp_valid[i] = (state_q == RESP) && (id_q == IDW'(i));
        end
    end

    assign rsp_result = (state_q == RESP) ? res_q : '0;
    assign rsp_err    = (state_q == RESP) ? err_q : 1'b0;

endmodule

// File: tb/tb_gcd_lcm_arbiter.sv
module tb_gcd_lcm_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int TMO  = 16;

    logic              clk;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   req_op;
    logic [NREQ*W-1:0] req_x;
    logic [NREQ*W-1:0] req_y;
    logic [NREQ-1:0]   rsp_valid;
    logic [W-1:0]      rsp_result;
    logic              rsp_err;
    logic              u_start;
    logic              u_op;
    logic [W-1:0]      u_x;
    logic [W-1:0]      u_y;
    logic              u_clr;
    logic              u_done;
    logic [W-1:0]      u_result;
    logic              busy;

    int n_chk;
    int n_pass;

    // Behavioural compute unit: finishes after delay_cfg+1 cycles of start.
    int unsigned delay_cfg;
    int unsigned ucnt;

    gcd_lcm_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_op     (req_op),
        .req_x      (req_x),
        .req_y      (req_y),
        .rsp_valid  (rsp_valid),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .u_start    (u_start),
        .u_op       (u_op),
        .u_x        (u_x),
        .u_y        (u_y),
        .u_clr      (u_clr),
        .u_done     (u_done),
        .u_result   (u_result),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unit side: subtraction-based GCD, LCM truncated to W bits.
    function automatic int unit_calc(input logic op, input logic [W-1:0] x, input logic [W-1:0] y);
        int a;
        int b;
        int g;
        a = int'(x);
        b = int'(y);
        if (a == 0 || b == 0) return 0;
        while (a != b) begin
            if (a > b) a = a - b;
            else       b = b - a;
        end
        g = a;
        if (op) return ((int'(x) / g) * int'(y)) % (1 << W);
        return g;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset)                 ucnt <= 0;
        else if (u_start && !u_done) ucnt <= ucnt + 1;
        else                       ucnt <= 0;
    end

    assign u_done = u_start && (ucnt == delay_cfg);
    always_comb u_result = W'(unit_calc(u_op, u_x, u_y));

    // Reference: Euclid with modulo, LCM = x*y/gcd mod 2^W, zero => error.
    function automatic int ref_gcd(input int a0, input int b0);
        int a;
        int b;
        int t;
        a = a0;
        b = b0;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic int ref_res(input logic op, input int x, input int y);
        int g;
        if (x == 0 || y == 0) return 0;
        g = ref_gcd(x, y);
        if (op) return (x * y / g) % (1 << W);
        return g;
    endfunction

    function automatic int rr_ref(input int last, input logic [NREQ-1:0] r);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] rnd_opnd();
        if ($urandom_range(0, 9) == 0) return '0;
        return W'($urandom_range(1, 255));
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    task automatic set_opnd(input int id, input logic op, input logic [W-1:0] x, input logic [W-1:0] y);
        req_op[id]      = op;
        req_x[id*W +: W] = x;
        req_y[id*W +: W] = y;
    endtask

    task automatic do_reset();
        @(negedge clk);
        req   = '0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_rsp(output logic [NREQ-1:0] v, output logic [W-1:0] r, output logic e);
        int cyc;
        v   = '0;
        r   = '0;
        e   = 1'b0;
        cyc = 0;
        while (v == '0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (rsp_valid != '0) begin
                v = rsp_valid;
                r = rsp_result;
                e = rsp_err;
            end
        end
    endtask

    // One isolated operation from IDLE, with cycle-level monitoring of the
    // unit interface. The requester scrambles its inputs after the grant.
    task automatic run_op(input string tag, input int id, input logic op,
                          input logic [W-1:0] x, input logic [W-1:0] y,
                          input int dly, input int eres, input logic eerr,
                          input int ecyc, input int estart, input int eclr);
        int             cyc;
        int             sc;
        int             cc;
        logic           got;
        logic           bad;
        logic [NREQ-1:0] rv;
        logic [W-1:0]   rr;
        logic           re;
        delay_cfg = dly;
        set_opnd(id, op, x, y);
        req[id] = 1'b1;
        cyc = 0; sc = 0; cc = 0; got = 1'b0; bad = 1'b0;
        rv = '0; rr = '0; re = 1'b0;
        while (!got && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (u_start) begin
                sc++;
                if (u_op !== op || u_x !== x || u_y !== y) bad = 1'b1;
                if (u_clr) bad = 1'b1;
            end
            if (u_clr) cc++;
            if (rsp_valid != '0) begin
                got = 1'b1;
                rv  = rsp_valid;
                rr  = rsp_result;
                re  = rsp_err;
                if (u_start) bad = 1'b1;
            end else if (cyc == 1) begin
                set_opnd(id, ~op, ~x, y + 8'd1);
            end
        end
        req[id] = 1'b0;
        chk({tag, "_valid"},  32'(rv), 32'(1 << id));
        chk({tag, "_result"}, 32'(rr), 32'(eres));
        chk({tag, "_err"},    32'(re), 32'(eerr));
        chk({tag, "_cycles"}, 32'(cyc), 32'(ecyc));
        chk({tag, "_start_cycles"}, 32'(sc), 32'(estart));
        chk({tag, "_clr_cycles"},   32'(cc), 32'(eclr));
        chk({tag, "_unit_if_stable"}, 32'(bad), 32'(0));
        @(negedge clk);
        chk({tag, "_idle_after"}, 32'({busy, rsp_valid, rsp_result, rsp_err}), 32'(0));
    endtask

    logic [NREQ-1:0] v;
    logic [W-1:0]    r;
    logic            e;
    int              last;
    int              pred;
    int              exp_seq[5] = '{0, 1, 2, 3, 0};

    initial begin
        n_chk     = 0;
        n_pass    = 0;
        delay_cfg = 2;
        reset     = 1'b1;
        req       = '0;
        req_op    = '0;
        req_x     = '0;
        req_y     = '0;

        // Reset state
        @(negedge clk);
        chk("rst_outputs", 32'({rsp_valid, rsp_result, rsp_err, u_start, u_op, u_clr, busy}), 32'(0));
        chk("rst_operands", 32'({u_x, u_y}), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // GCD and LCM through the unit, zero operand, timeout, done-at-timeout
        run_op("gcd48_18", 0, 1'b0, 8'd48, 8'd18, 5, 6, 1'b0, 7, 6, 0);
        run_op("lcm4_6",   1, 1'b1, 8'd4,  8'd6,  3, 12, 1'b0, 5, 4, 0);
        run_op("zero_x",   3, 1'b0, 8'd0,  8'd9,  2, 0, 1'b1, 1, 0, 0);
        run_op("timeout",  2, 1'b0, 8'd5,  8'd7,  1000, 0, 1'b1, TMO + 2, TMO, 1);
        run_op("after_to", 1, 1'b0, 8'd12, 8'd8,  3, 4, 1'b0, 5, 4, 0);
        run_op("done_at_to", 3, 1'b1, 8'd3, 8'd5, TMO - 1, 15, 1'b0, TMO + 1, TMO, 0);

        // Round-robin order with all requesting after reset
        do_reset();
        delay_cfg = 2;
        for (int i = 0; i < NREQ; i++) set_opnd(i, 1'b0, W'(i + 2), 8'd12);
        req = '1;
        for (int n = 0; n < 5; n++) begin
            wait_rsp(v, r, e);
            chk($sformatf("rr_order_%0d", n), 32'(v), 32'(1 << exp_seq[n]));
            if (n == 4) req = 4'b0101;
        end
        wait_rsp(v, r, e);
        chk("rr_0101_first", 32'(v), 32'(4'b0100));
        chk("rr_0101_res", 32'(r), 32'(ref_res(1'b0, 4, 12)));
        wait_rsp(v, r, e);
        chk("rr_0101_second", 32'(v), 32'(4'b0001));
        req = '0;
        @(negedge clk);

        // Reset mid-RUN: after last grant 0 a plain arbiter would pick 1 next
        run_op("pre_rst", 0, 1'b0, 8'd9, 8'd6, 2, 3, 1'b0, 4, 3, 0);
        delay_cfg = 1000;
        set_opnd(2, 1'b0, 8'd10, 8'd4);
        req = 4'b0100;
        repeat (3) @(negedge clk);
        chk("mid_run_started", 32'(u_start), 32'(1));
        reset = 1'b1;
        #1;
        chk("mid_rst_outputs", 32'({rsp_valid, rsp_result, rsp_err, u_start, u_clr, busy}), 32'(0));
        chk("mid_rst_operands", 32'({u_x, u_y, u_op}), 32'(0));
        repeat (2) begin
            @(negedge clk);
            chk("mid_rst_no_rsp", 32'({rsp_valid, u_clr}), 32'(0));
        end
        delay_cfg = 2;
        for (int i = 0; i < NREQ; i++) set_opnd(i, 1'b0, 8'd15, W'(5 * (i + 1)));
        req   = '1;
        reset = 1'b0;
        wait_rsp(v, r, e);
        chk("post_rst_grant", 32'(v), 32'(4'b0001));
        chk("post_rst_res", 32'({r, e}), 32'({8'd5, 1'b0}));
        req = '0;
        @(negedge clk);

        // Randomized traffic against the reference model
        do_reset();
        last = NREQ - 1;
        for (int n = 0; n < 200; n++) begin
            if (req == '0) begin
                for (int i = 0; i < NREQ; i++) begin
                    if ($urandom_range(0, 1) == 1 || i == n % NREQ) begin
                        set_opnd(i, 1'($urandom_range(0, 1)), rnd_opnd(), rnd_opnd());
                        req[i] = 1'b1;
                    end
                end
            end
            delay_cfg = $urandom_range(0, 10);
            pred = rr_ref(last, req);
            wait_rsp(v, r, e);
            chk($sformatf("rnd_grant_%0d", n), 32'(v), 32'(1 << pred));
            chk($sformatf("rnd_result_%0d", n), 32'(r),
                32'(ref_res(req_op[pred], int'(req_x[pred*W +: W]), int'(req_y[pred*W +: W]))));
            chk($sformatf("rnd_err_%0d", n), 32'(e),
                32'((req_x[pred*W +: W] == '0) || (req_y[pred*W +: W] == '0)));
            last = pred;
            req[pred] = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && $urandom_range(0, 2) == 0) begin
                    set_opnd(i, 1'($urandom_range(0, 1)), rnd_opnd(), rnd_opnd());
                    req[i] = 1'b1;
                end
            end
        end
        req = '0;
        repeat (3) @(negedge clk);
        chk("final_idle", 32'({busy, rsp_valid}), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
